// File: rtl/trace_arbiter_if.sv
// rtl/trace_arbiter_if.sv - tracker-source and trace-sink signal bundle for trace_arbiter
interface trace_arbiter_if #(
  parameter int NUM_SRC     = 4,
  parameter int TRACE_WIDTH = 128
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]             src_valid;
  logic [NUM_SRC*TRACE_WIDTH-1:0] src_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [TRACE_WIDTH-1:0]         out_data;
  logic [SRC_W-1:0]               out_src;

  modport master (
    output src_valid, src_data, out_ready,
    input  out_valid, out_data, out_src
  );

  modport slave (
    input  src_valid, src_data, out_ready,
    output out_valid, out_data, out_src
  );
endinterface

// File: rtl/trace_arbiter.sv
// rtl/trace_arbiter.sv - per-source trace FIFOs merged round-robin into one registered stream
module trace_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int TRACE_WIDTH = 128,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         clear_ovf,
  output logic [NUM_SRC-1:0]           ovf_sticky,
  output logic [NUM_SRC*CNT_WIDTH-1:0] drop_count,
  output logic                         idle,
  trace_arbiter_if.slave               bus
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic {S_EMPTY, S_FULL} state_t;
  state_t state, state_nx;

  logic [TRACE_WIDTH-1:0] mem [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr [NUM_SRC];
  logic [PTR_W-1:0]       rd_ptr [NUM_SRC];
  logic [OCC_W-1:0]       occ    [NUM_SRC];
  logic [CNT_WIDTH-1:0]   cnt    [NUM_SRC];

  logic [SRC_W-1:0]       last_grant, pick, cand, src_q;
  logic [TRACE_WIDTH-1:0] data_q;
  logic                   have_pick, load_ok, do_load;
  logic [NUM_SRC-1:0]     empty, full, pop, push, drop;

  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      empty[i] = (occ[i] == '0);
      full[i]  = (occ[i] == OCC_W'(FIFO_DEPTH));
    end
  end

  // Walk from the farthest candidate back to the nearest so the nearest non-empty one wins.
  always_comb begin
    pick      = '0;
    cand      = '0;
    have_pick = 1'b0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = SRC_W'((int'(last_grant) + k) % NUM_SRC);
      if (!empty[cand]) begin
        pick      = cand;
        have_pick = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_EMPTY;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_EMPTY: if (do_load) state_nx = S_FULL;
      S_FULL:  if (bus.out_ready && !do_load) state_nx = S_EMPTY;
      default: state_nx = S_EMPTY;
    endcase
  end

  always_comb begin
    bus.out_valid = (state == S_FULL);
    load_ok       = enable && ((state == S_EMPTY) || bus.out_ready);
    do_load       = load_ok && have_pick;
  end

  // A full FIFO still takes a push when it is being popped in the same cycle.
  always_comb begin
    pop  = '0;
    push = '0;
    drop = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i]  = do_load && (pick == SRC_W'(i));
      push[i] = bus.src_valid[i] && (!full[i] || pop[i]);
      drop[i] = bus.src_valid[i] && full[i] && !pop[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= bus.src_data[i*TRACE_WIDTH +: TRACE_WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= SRC_W'(NUM_SRC - 1);
      data_q     <= '0;
      src_q      <= '0;
      ovf_sticky <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        occ[i]    <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      if (do_load) begin
        data_q     <= mem[pick][rd_ptr[pick]];
        src_q      <= pick;
        last_grant <= pick;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])      occ[i] <= occ[i] + 1'b1;
        else if (pop[i] && !push[i]) occ[i] <= occ[i] - 1'b1;
        // A drop coinciding with clear restarts the count at one.
        if (drop[i]) begin
          ovf_sticky[i] <= 1'b1;
          if (clear_ovf)          cnt[i] <= CNT_WIDTH'(1);
          else if (cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
        end else if (clear_ovf) begin
          ovf_sticky[i] <= 1'b0;
          cnt[i]        <= '0;
        end
      end
    end
  end

  always_comb begin
    bus.out_data = data_q;
    bus.out_src  = src_q;
    idle         = (&empty) && (state == S_EMPTY);
    drop_count   = '0;
    for (int i = 0; i < NUM_SRC; i++)
      drop_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
  end
endmodule

// File: tb/tb_trace_arbiter.sv
// tb/tb_trace_arbiter.sv - directed vector table plus corner-case sequences for trace_arbiter
module tb_trace_arbiter;
  localparam int NS = 4;
  localparam int TW = 128;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            enable;
  logic            clear_ovf;
  logic [NS-1:0]   ovf_sticky;
  logic [NS*CW-1:0] drop_count;
  logic            idle;

  trace_arbiter_if #(.NUM_SRC(NS), .TRACE_WIDTH(TW)) bus ();

  trace_arbiter #(.NUM_SRC(NS), .TRACE_WIDTH(TW), .FIFO_DEPTH(4), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .clear_ovf (clear_ovf),
    .ovf_sticky(ovf_sticky),
    .drop_count(drop_count),
    .idle      (idle),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sv;
    logic [7:0]  tag;
    logic        rdy;
    logic        ev;
    logic [1:0]  es;
    logic [15:0] ed;
    logic        eidle;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(logic [3:0] sv, logic [7:0] tag, logic rdy, logic ev,
                              logic [1:0] es, logic [15:0] ed, logic eidle);
    vec_t v;
    v.sv = sv; v.tag = tag; v.rdy = rdy; v.ev = ev; v.es = es; v.ed = ed; v.eidle = eidle;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Record from source i carries {i, tag} in its low 16 bits so both origin and order are visible.
  task automatic set_src(input logic [3:0] v, input logic [7:0] tag);
    bus.src_valid = v;
    for (int i = 0; i < NS; i++)
      bus.src_data[i*TW +: TW] = TW'(i * 256 + int'(tag));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] dc(int i);
    return drop_count[i*CW +: CW];
  endfunction

  initial begin
    enable        = 1'b1;
    clear_ovf     = 1'b0;
    bus.out_ready = 1'b1;
    set_src(4'b0000, 8'h00);

    #12;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_idle", 128'(idle), 128'(1));
    chk("rst_ovf", 128'(ovf_sticky), 128'(0));
    chk("rst_drop", 128'(drop_count), 128'(0));
    chk("rst_out_data", bus.out_data, 128'(0));
    chk("rst_out_src", 128'(bus.out_src), 128'(0));
    @(negedge clk);
    rst = 1'b1;

    // Fairness: all sources push tags 1..4, then drain 0,1,2,3 repeated.
    for (int n = 1; n <= 18; n++) begin
      logic [3:0] sv;
      sv = (n <= 4) ? 4'hF : 4'h0;
      if (n == 1) add(sv, 8'(n), 1'b1, 1'b0, 2'd0, 16'h0, 1'b0);
      else if (n <= 17) begin
        int r;
        r = n - 2;
        add(sv, 8'(n), 1'b1, 1'b1, 2'(r % 4), 16'((r % 4) * 256 + r / 4 + 1), 1'b0);
      end else add(sv, 8'(n), 1'b1, 1'b0, 2'd0, 16'h0, 1'b1);
    end
    // Single record from source 0.
    add(4'b0001, 8'hA5, 1'b1, 1'b0, 2'd0, 16'h0,    1'b0);
    add(4'b0000, 8'h00, 1'b1, 1'b1, 2'd0, 16'h00A5, 1'b0);
    add(4'b0000, 8'h00, 1'b1, 1'b0, 2'd0, 16'h0,    1'b1);

    foreach (tbl[j]) begin
      set_src(tbl[j].sv, tbl[j].tag);
      bus.out_ready = tbl[j].rdy;
      step();
      chk($sformatf("vec%0d_valid", j), 128'(bus.out_valid), 128'(tbl[j].ev));
      if (tbl[j].ev) begin
        chk($sformatf("vec%0d_data", j), bus.out_data, 128'(tbl[j].ed));
        chk($sformatf("vec%0d_src", j), 128'(bus.out_src), 128'(tbl[j].es));
      end
      chk($sformatf("vec%0d_idle", j), 128'(idle), 128'(tbl[j].eidle));
    end
    set_src(4'b0000, 8'h00);

    // Backpressure: six pushes into source 1 with the sink stalled, one dropped.
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      set_src(4'b0010, 8'(k));
      step();
    end
    set_src(4'b0000, 8'h00);
    chk("bp_valid", 128'(bus.out_valid), 128'(1));
    chk("bp_data", bus.out_data, 128'(16'h0101));
    chk("bp_ovf", 128'(ovf_sticky), 128'(4'b0010));
    chk("bp_drop1", 128'(dc(1)), 128'(1));
    chk("bp_drop0", 128'(dc(0)), 128'(0));
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("bp_drain%0d_valid", k), 128'(bus.out_valid), 128'(1));
      chk($sformatf("bp_drain%0d_data", k), bus.out_data, 128'(16'h0100 + k));
      chk($sformatf("bp_drain%0d_src", k), 128'(bus.out_src), 128'(1));
      step();
    end
    chk("bp_end_valid", 128'(bus.out_valid), 128'(0));
    chk("bp_end_idle", 128'(idle), 128'(1));

    // Full FIFO 2 pushed in the same cycle it is popped: nothing dropped.
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      set_src(4'b0100, 8'(k));
      step();
    end
    set_src(4'b0100, 8'd6);
    bus.out_ready = 1'b1;
    step();
    set_src(4'b0000, 8'h00);
    chk("fp_ovf", 128'(ovf_sticky), 128'(4'b0010));
    chk("fp_drop2", 128'(dc(2)), 128'(0));
    for (int k = 2; k <= 6; k++) begin
      chk($sformatf("fp_drain%0d_valid", k), 128'(bus.out_valid), 128'(1));
      chk($sformatf("fp_drain%0d_data", k), bus.out_data, 128'(16'h0200 + k));
      step();
    end
    chk("fp_end_idle", 128'(idle), 128'(1));

    // enable=0 holds off grants while pushes still land.
    enable = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      set_src(4'b1000, 8'(k));
      step();
      chk($sformatf("en_hold%0d_valid", k), 128'(bus.out_valid), 128'(0));
    end
    set_src(4'b0000, 8'h00);
    step();
    chk("en_hold_valid", 128'(bus.out_valid), 128'(0));
    chk("en_hold_idle", 128'(idle), 128'(0));
    enable = 1'b1;
    step();
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("en_drain%0d_valid", k), 128'(bus.out_valid), 128'(1));
      chk($sformatf("en_drain%0d_data", k), bus.out_data, 128'(16'h0300 + k));
      step();
    end
    chk("en_end_idle", 128'(idle), 128'(1));
    chk("en_drop3", 128'(dc(3)), 128'(0));

    // Overflow on source 0, then a drop coinciding with clear_ovf, then a plain clear.
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      set_src(4'b0001, 8'(k));
      step();
    end
    chk("ov_ovf", 128'(ovf_sticky), 128'(4'b0011));
    chk("ov_drop0", 128'(dc(0)), 128'(1));
    set_src(4'b0001, 8'd7);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    set_src(4'b0000, 8'h00);
    chk("clrdrop_ovf", 128'(ovf_sticky), 128'(4'b0001));
    chk("clrdrop_drop0", 128'(dc(0)), 128'(1));
    chk("clrdrop_drop1", 128'(dc(1)), 128'(0));
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk("clr_ovf", 128'(ovf_sticky), 128'(0));
    chk("clr_drop", 128'(drop_count), 128'(0));

    // Asynchronous reset between edges while a record is held and a push is pending.
    chk("ar_pre_valid", 128'(bus.out_valid), 128'(1));
    set_src(4'b0001, 8'd8);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_valid", 128'(bus.out_valid), 128'(0));
    chk("ar_idle", 128'(idle), 128'(1));
    chk("ar_data", bus.out_data, 128'(0));
    set_src(4'b0000, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("ar_post_idle", 128'(idle), 128'(1));
    chk("ar_post_valid", 128'(bus.out_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trace_arbiter.md
Name: trace_arbiter

Overview:
- Merges trace records from NUM_SRC pipeline-stage trackers into one serial trace stream. Sources are the IF, ID, EX and MEM trackers.
- Trackers emit records as single-cycle ready pulses and cannot be stalled, so each source gets a small FIFO.
- A round-robin scheduler drains the FIFOs into one registered valid/ready output that feeds the trace sink.
- Overflow is reported per source; records are never silently corrupted.

Parameters:
- NUM_SRC, 4: number of tracker sources; index 0 = IF.
- TRACE_WIDTH, 128: bits per trace record, i.e. the packed trace_output width.
- FIFO_DEPTH, 4: entries per source FIFO; power of two, ≥2.
- CNT_WIDTH, 16: width of each per-source drop counter.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous active-low reset; asserted when 0, released synchronously by the design's reset source.
- enable  input  1  1 = grants allowed; 0 = FIFOs still accept, no new grants issued.
- src_valid  input  NUM_SRC  per-source one-cycle record-ready pulse.
- src_data  input  NUM_SRC*TRACE_WIDTH  per-source record; slice i = [i*TRACE_WIDTH +: TRACE_WIDTH].
- out_valid  output  1  output record valid.
- out_ready  input  1  sink accepts when out_valid & out_ready.
- out_data  output  TRACE_WIDTH  granted record.
- out_src  output  $clog2(NUM_SRC)  source index of out_data.
- clear_ovf  input  1  synchronous clear of ovf_sticky and drop_count.
- ovf_sticky  output  NUM_SRC  per-source sticky overflow flag.
- drop_count  output  NUM_SRC*CNT_WIDTH  per-source saturating dropped-record count.
- idle  output  1  all FIFOs empty and out_valid=0.

Behaviour:
- Reset (rst=0, asynchronous): FIFO pointers and occupancy = 0; out_valid=0; out_data=0; out_src=0; last_grant=NUM_SRC-1, so the first grant goes to source 0; ovf_sticky=0; drop_count=0; idle=1.
- Push:
  - src_valid[i] at edge writes src_data slice into FIFO i if not full.
  - If FIFO i is full but popped in the same cycle, the push is accepted (pop before push).
  - Otherwise the record is dropped: ovf_sticky[i]<=1 and drop_count[i] increments, saturating at 2^CNT_WIDTH-1.
- Output register FSM, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1; out_data and out_src held stable until the handshake.
- Load condition:
  - Loading is allowed when enable=1 and (state==EMPTY or out_valid&out_ready).
  - The arbiter picks the first non-empty FIFO searching last_grant+1, +2, … modulo NUM_SRC.
  - On a load: pop that FIFO, load out_data/out_src, last_grant<=index, state FULL.
- EMPTY→FULL on load.
- FULL→EMPTY on handshake when no load occurs.
- FULL→FULL on handshake plus load (back-to-back records, one per cycle, no bubble).
- Latency: src_valid at edge N → out_valid=1 after edge N+1, assuming the output is free and enable=1. No combinational src→out path.
- enable=0: the current FULL record remains and may still complete its handshake; no new load. Pushes and drop accounting continue.
- Per-source ordering is preserved. Cross-source order is round-robin only; the sink reorders by timestamps.
- Simultaneous push and pop on the same FIFO: occupancy unchanged, data correct.
- Simultaneous clear_ovf and a drop: the drop wins; flag=1, count=1.
- Reset mid-transfer discards all buffered records. out_valid drops asynchronously.
- idle = (all occupancy==0) & ~out_valid; registered-state derived, no src_valid term.

Test Plan:
- Single record: src_valid[0] pulse with data 0xA5 (zero-extended), out_ready=1 → out_valid one cycle later, out_data=0xA5, out_src=0, then idle=1.
- Fairness: all four sources pulse every cycle for 4 cycles, out_ready=1 → out_src sequence 0,1,2,3,0,1,2,3…; per-source data arrives in push order.
- Backpressure/overflow: out_ready=0, source 1 pulses 6 times (FIFO_DEPTH=4) → 1 record in the output register, 4 in the FIFO, 1 dropped; ovf_sticky[1]=1, drop_count[1]=1. Release out_ready → 5 records drain in order.
- Full plus pop same cycle: FIFO 2 full, handshake pops FIFO 2 while src_valid[2]=1 → no drop; occupancy stays 4.
- enable=0 with 3 queued records → out_valid stays 0, with no pushes lost. enable=1 → records drain with 1-cycle spacing.
- Async reset asserted mid-burst between clock edges → out_valid=0 immediately, idle=1; clear_ovf pulse zeroes flags and counters.
